// File: rtl/nv_nvdla_sdp_hls_x_out_cvt.sv
// nv_nvdla_sdp_hls_x_out_cvt
// Output converter for the SDP X path. It subtracts an offset, multiplies by a
// scale, applies a rounding arithmetic right shift, and saturates to int16 or
// int8. The datapath is a two-stage valid/ready pipeline.
// Optional feature: define NVDLA_SDP_CVT_SAT_CNT_EN to build the sticky
// saturation event counter. When it is undefined, sat_cnt is tied to zero.
module nv_nvdla_sdp_hls_x_out_cvt #(
    parameter int SAT_CNT_W = 32
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic [31:0]          cfg_cvt_offset,
    input  logic [15:0]          cfg_cvt_scale,
    input  logic [5:0]           cfg_cvt_shift,
    input  logic                 cfg_out_int8,
    input  logic                 cfg_sat_cnt_clr,
    input  logic                 chn_in_pvld,
    output logic                 chn_in_prdy,
    input  logic [31:0]          chn_data_in,
    output logic                 chn_out_pvld,
    input  logic                 chn_out_prdy,
    output logic [15:0]          chn_data_out,
    output logic                 chn_sat_out,
    output logic [SAT_CNT_W-1:0] sat_cnt
);

    logic                s1_vld_r;
    logic [48:0]         s1_prod_r;
    logic                s2_vld_r;
    logic [15:0]         s2_data_r;
    logic                s2_sat_r;

    logic                s2_rdy_s;
    logic                s1_rdy_s;
    logic [32:0]         diff_s;
    logic [48:0]         diff_ext_s;
    logic [48:0]         scale_ext_s;
    logic [48:0]         prod_s;
    logic [49:0]         rnd_s;
    logic signed [49:0]  sum_s;
    logic signed [49:0]  shifted_s;
    logic signed [49:0]  lim_hi_s;
    logic signed [49:0]  lim_lo_s;
    logic [15:0]         clip_data_s;
    logic                clip_sat_s;
    logic                out_hs_s;

    // Pipeline ready chain: each stage accepts a beat when it is empty or when its content leaves
    always_comb begin
        s2_rdy_s = ~s2_vld_r | chn_out_prdy;
        s1_rdy_s = ~s1_vld_r | s2_rdy_s;
    end

    assign chn_in_prdy  = s1_rdy_s;
    assign chn_out_pvld = s2_vld_r;
    assign chn_data_out = s2_data_r;
    assign chn_sat_out  = s2_sat_r;
    assign out_hs_s     = s2_vld_r & chn_out_prdy;

    // S1 arithmetic: exact 33-bit difference times 16-bit scale. Operands are sign-extended to 49 bits, so the low 49 bits of the product are exact
    always_comb begin
        diff_s      = {chn_data_in[31], chn_data_in} - {cfg_cvt_offset[31], cfg_cvt_offset};
        diff_ext_s  = {{16{diff_s[32]}}, diff_s};
        scale_ext_s = {{33{cfg_cvt_scale[15]}}, cfg_cvt_scale};
        prod_s      = diff_ext_s * scale_ext_s;
    end

    // S2 arithmetic: round-half-up shift, then clamp to the selected output range
    always_comb begin
        rnd_s       = 50'd0;
        clip_data_s = 16'd0;
        clip_sat_s  = 1'b0;
        if (cfg_cvt_shift != 6'd0) begin
            rnd_s = 50'd1 << (cfg_cvt_shift - 6'd1);
        end else begin
            rnd_s = 50'd0;
        end
        // A 50-bit sum keeps the rounding addend from overflowing the 49-bit product
        sum_s     = $signed({s1_prod_r[48], s1_prod_r}) + $signed(rnd_s);
        shifted_s = sum_s >>> cfg_cvt_shift;
        if (cfg_out_int8) begin
            lim_hi_s = 50'sd127;
            lim_lo_s = -50'sd128;
        end else begin
            lim_hi_s = 50'sd32767;
            lim_lo_s = -50'sd32768;
        end
        if (shifted_s > lim_hi_s) begin
            clip_data_s = lim_hi_s[15:0];
            clip_sat_s  = 1'b1;
        end else if (shifted_s < lim_lo_s) begin
            clip_data_s = lim_lo_s[15:0];
            clip_sat_s  = 1'b1;
        end else begin
            // An in-range int8 value is already sign-extended through bit 15
            clip_data_s = shifted_s[15:0];
            clip_sat_s  = 1'b0;
        end
    end

    // S1 valid bit: loads whenever S1 is ready, which drops it if no beat is offered
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            s1_vld_r <= 1'b0;
        end else if (s1_rdy_s) begin
            s1_vld_r <= chn_in_pvld;
        end else begin
            s1_vld_r <= s1_vld_r;
        end
    end

    // S1 product register: captures only on an input handshake
    always_ff @(posedge nvdla_core_clk) begin
        if (chn_in_pvld & s1_rdy_s) begin
            s1_prod_r <= prod_s;
        end else begin
            s1_prod_r <= s1_prod_r;
        end
    end

    // S2 valid bit: refills from S1 when S2 is ready, so a simultaneous leave and enter keeps it set
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            s2_vld_r <= 1'b0;
        end else if (s2_rdy_s) begin
            s2_vld_r <= s1_vld_r;
        end else begin
            s2_vld_r <= s2_vld_r;
        end
    end

    // S2 result registers: held while stalled, so the output stays stable under backpressure
    always_ff @(posedge nvdla_core_clk) begin
        if (s1_vld_r & s2_rdy_s) begin
            s2_data_r <= clip_data_s;
            s2_sat_r  <= clip_sat_s;
        end else begin
            s2_data_r <= s2_data_r;
            s2_sat_r  <= s2_sat_r;
        end
    end

`ifdef NVDLA_SDP_CVT_SAT_CNT_EN
    logic [SAT_CNT_W-1:0] sat_cnt_r;

    // Saturation counter: clear wins over increment, and the count sticks at all-ones
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            sat_cnt_r <= {SAT_CNT_W{1'b0}};
        end else if (cfg_sat_cnt_clr) begin
            sat_cnt_r <= {SAT_CNT_W{1'b0}};
        end else if (out_hs_s & s2_sat_r & (sat_cnt_r != {SAT_CNT_W{1'b1}})) begin
            sat_cnt_r <= sat_cnt_r + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sat_cnt_r <= sat_cnt_r;
        end
    end

    assign sat_cnt = sat_cnt_r;
`else
    logic unused_cnt_s;

    assign unused_cnt_s = cfg_sat_cnt_clr ^ out_hs_s;
    assign sat_cnt      = {SAT_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_hls_x_out_cvt.sv
// Self-checking bench for nv_nvdla_sdp_hls_x_out_cvt. Directed beats push
// hand-computed results into a queue, and a monitor pops and compares them on
// every output handshake.
module tb_nv_nvdla_sdp_hls_x_out_cvt;

    logic        clk;
    logic        rst;
    logic [31:0] cfg_cvt_offset;
    logic [15:0] cfg_cvt_scale;
    logic [5:0]  cfg_cvt_shift;
    logic        cfg_out_int8;
    logic        cfg_sat_cnt_clr;
    logic        chn_in_pvld;
    logic        chn_in_prdy;
    logic [31:0] chn_data_in;
    logic        chn_out_pvld;
    logic        chn_out_prdy;
    logic [15:0] chn_data_out;
    logic        chn_sat_out;
    logic [31:0] sat_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [16:0] sb_q[$];
    logic        prev_stall;
    logic [16:0] prev_out;

    nv_nvdla_sdp_hls_x_out_cvt #(.SAT_CNT_W(32)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_cvt_offset (cfg_cvt_offset),
        .cfg_cvt_scale  (cfg_cvt_scale),
        .cfg_cvt_shift  (cfg_cvt_shift),
        .cfg_out_int8   (cfg_out_int8),
        .cfg_sat_cnt_clr(cfg_sat_cnt_clr),
        .chn_in_pvld    (chn_in_pvld),
        .chn_in_prdy    (chn_in_prdy),
        .chn_data_in    (chn_data_in),
        .chn_out_pvld   (chn_out_pvld),
        .chn_out_prdy   (chn_out_prdy),
        .chn_data_out   (chn_data_out),
        .chn_sat_out    (chn_sat_out),
        .sat_cnt        (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every output beat against the scoreboard and checks hold stability
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && chn_out_pvld)
                chk("hold_stable", {15'd0, chn_sat_out, chn_data_out}, {15'd0, prev_out});
            if (chn_out_pvld && chn_out_prdy) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    chk("out_beat", {15'd0, chn_sat_out, chn_data_out}, {15'd0, sb_q.pop_front()});
                end
            end
            prev_stall <= chn_out_pvld & ~chn_out_prdy;
            prev_out   <= {chn_sat_out, chn_data_out};
        end
    end

    // Offer one beat; the expected result is queued at the handshake edge
    task automatic send(input logic [31:0] din, input logic [15:0] edata, input logic esat);
        bit hs;
        int n;
        chn_in_pvld = 1'b1;
        chn_data_in = din;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = chn_in_prdy;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) chk("send_timeout", 32'd1, 32'd0);
        else sb_q.push_back({esat, edata});
        if (hs && esat) exp_cnt++;
        chn_in_pvld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || chn_out_pvld) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", {31'd0, chn_out_pvld}, 32'd0);
    endtask

    function automatic logic [31:0] exp_sat_cnt(input int c);
`ifdef NVDLA_SDP_CVT_SAT_CNT_EN
        return 32'(c);
`else
        return 32'(0 * c);
`endif
    endfunction

    task automatic set_cfg(input logic [31:0] off, input logic [15:0] sc, input logic [5:0] sh, input logic i8);
        cfg_cvt_offset = off;
        cfg_cvt_scale  = sc;
        cfg_cvt_shift  = sh;
        cfg_out_int8   = i8;
    endtask

    initial begin
        logic [31:0] vals [3];
        int idx;
        bit hs;
        rst = 1'b1;
        cfg_sat_cnt_clr = 1'b0;
        chn_in_pvld = 1'b0;
        chn_data_in = 32'd0;
        chn_out_prdy = 1'b1;
        set_cfg(32'd0, 16'd1, 6'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pvld", {31'd0, chn_out_pvld}, 32'd0);
        chk("rst_prdy", {31'd0, chn_in_prdy}, 32'd1);
        chk("rst_cnt", sat_cnt, 32'd0);
        @(posedge clk);
        #1;

        // Basic conversion and two-cycle latency
        set_cfg(32'd200, 16'd3, 6'd2, 1'b0);
        send(32'd1000, 16'd600, 1'b0);
        @(negedge clk);
        chk("lat_cycle1", {31'd0, chn_out_pvld}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2", {31'd0, chn_out_pvld}, 32'd1);
        drain();

        // Round-half-up, back to back
        set_cfg(32'd0, 16'd1, 6'd1, 1'b0);
        send(32'd5, 16'd3, 1'b0);
        send(-32'sd5, 16'hFFFE, 1'b0);
        drain();

        // Large product with a wide shift: -1000000 * -32768 >> 20 = 31250
        set_cfg(32'd0, 16'h8000, 6'd20, 1'b0);
        send(-32'sd1000000, 16'd31250, 1'b0);
        drain();

        // Saturation, int16 then int8
        set_cfg(32'd0, 16'd1, 6'd0, 1'b0);
        send(32'd65536, 16'h7FFF, 1'b1);
        drain();
        chk("cnt_1", sat_cnt, exp_sat_cnt(exp_cnt));
        set_cfg(32'd0, 16'd1, 6'd0, 1'b1);
        send(-32'sd300, 16'hFF80, 1'b1);
        drain();
        chk("cnt_2", sat_cnt, exp_sat_cnt(exp_cnt));
        send(32'd200, 16'h007F, 1'b1);
        send(-32'sd128, 16'hFF80, 1'b0);
        send(32'd127, 16'h007F, 1'b0);
        drain();
        set_cfg(32'd0, 16'd1, 6'd0, 1'b0);
        send(32'd32768, 16'h7FFF, 1'b1);
        send(-32'sd32769, 16'h8000, 1'b1);
        send(-32'sd32768, 16'h8000, 1'b0);
        drain();
        chk("cnt_5", sat_cnt, exp_sat_cnt(exp_cnt));

        // Backpressure: three beats offered over five stalled cycles
        chn_out_prdy = 1'b0;
        vals[0] = 32'd10;
        vals[1] = 32'd20;
        vals[2] = 32'd30;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            chn_in_pvld = 1'b1;
            chn_data_in = vals[idx];
            @(negedge clk);
            hs = chn_in_prdy;
            @(posedge clk);
            #1;
            if (hs) begin
                sb_q.push_back({1'b0, vals[idx][15:0]});
                idx++;
            end
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        @(negedge clk);
        chk("bp_prdy_low", {31'd0, chn_in_prdy}, 32'd0);
        @(posedge clk);
        #1 chn_out_prdy = 1'b1;
        send(vals[2], 16'd30, 1'b0);
        drain();

        // Reset with both stages full drops the in-flight beats
        chn_out_prdy = 1'b0;
        send(32'd70000, 16'h7FFF, 1'b1);
        send(32'd50, 16'd50, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        chk("mid_rst_pvld", {31'd0, chn_out_pvld}, 32'd0);
        chk("mid_rst_cnt", sat_cnt, 32'd0);
        @(posedge clk);
        #1 chn_out_prdy = 1'b1;
        send(32'd77, 16'd77, 1'b0);
        @(negedge clk);
        chk("post_rst_lat1", {31'd0, chn_out_pvld}, 32'd0);
        @(negedge clk);
        chk("post_rst_lat2", {31'd0, chn_out_pvld}, 32'd1);
        drain();

        // Clear coincident with a saturating handshake
        send(32'd40000, 16'h7FFF, 1'b1);
        drain();
        chk("pre_clr_cnt", sat_cnt, exp_sat_cnt(exp_cnt));
        send(32'd40000, 16'h7FFF, 1'b1);
        @(posedge clk);
        #1 cfg_sat_cnt_clr = 1'b1;
        chk("clr_align_pvld", {31'd0, chn_out_pvld}, 32'd1);
        @(posedge clk);
        #1 cfg_sat_cnt_clr = 1'b0;
        exp_cnt = 0;
        drain();
        chk("clr_wins", sat_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
